// File: rtl/jstk2_spi_responder.sv
// jstk2_spi_responder
//   SPI mode-0 slave that stands in for a PMOD JSTK2 joystick. Each frame it
//   serves a 5-byte snapshot of x_pos/y_pos/buttons, MSB first. It captures the
//   master's command byte and, for the set-LED command, the following R/G/B bytes.
//   All SPI pins are asynchronous to CLK and are oversampled.
//
//   Optional feature macro: JSTK_LED_CMD_EN. When it is defined, the set-LED
//   decode and the led_r/g/b registers are built. When it is undefined, the
//   LED outputs are tied to 0.
//
// Ports
//   CLK, RST_n          system clock, async active-low reset
//   CS_n, SCK, MOSI     SPI inputs from master (async)
//   MISO                SPI data to master (0 outside an active frame)
//   x_pos, y_pos        10-bit emulated positions
//   buttons             8-bit emulated button byte
//   cmd / cmd_valid     frame byte 0 and its one-cycle update strobe
//   led_r/g/b           RGB values from the last complete set-LED frame
//   txn_done            one-cycle pulse, frame of >= 40 bits completed
//   frame_err           one-cycle pulse, frame aborted before 40 bits
module jstk2_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_SET_LED = 8'h84
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       CS_n,
    input  logic       SCK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [7:0] buttons,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] led_r,
    output logic [7:0] led_g,
    output logic [7:0] led_b,
    output logic       txn_done,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, ACTIVE, OVERRUN} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic sck_d, cs_d;
    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    logic [39:0] tx_sr;
    logic [7:0]  rx_sr;
    logic [7:0]  rx_byte;
    logic [5:0]  bit_cnt;

    logic start, sample, shift, done, abort;

    // CS_n synchronizer resets to the asserted level. If CS_n is already low
    // when reset releases, no falling edge is seen. A new frame therefore needs
    // the master to release CS_n and assert it again.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_d;
    assign sck_fall = ~sck_s &  sck_d;
    assign cs_rise  =  cs_s  & ~cs_d;
    assign cs_fall  = ~cs_s  &  cs_d;

    assign rx_byte = {rx_sr[6:0], mosi_s};

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= state_nx;
    end

    // A CS_n edge takes priority over an SCK edge in the same cycle.
    // SCK edges are only qualified in ACTIVE, and only when CS_n is not rising.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        sample   = 1'b0;
        shift    = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    start    = 1'b1;
                    state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    sample = sck_rise;
                    shift  = sck_fall;
                    if (sck_rise && bit_cnt == 6'd39) state_nx = OVERRUN;
                end
            end
            OVERRUN: begin
                if (cs_rise) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            txn_done  <= 1'b0;
            frame_err <= 1'b0;
            MISO      <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            txn_done  <= done;
            frame_err <= abort;
            if (start) begin
                // Snapshot once per frame; later input changes do not reach the wire.
                tx_sr   <= {x_pos[7:0], 6'b0, x_pos[9:8],
                            y_pos[7:0], 6'b0, y_pos[9:8], buttons};
                bit_cnt <= '0;
            end
            if (sample) begin
                rx_sr   <= rx_byte;
                bit_cnt <= bit_cnt + 6'd1;
                if (bit_cnt == 6'd7) begin
                    cmd       <= rx_byte;
                    cmd_valid <= 1'b1;
                end
            end
            if (shift) tx_sr <= {tx_sr[38:0], 1'b0};
            // MISO is registered from the shift register. It reflects the
            // shifted value one cycle after the edge pulse is acted on.
            MISO <= (state == ACTIVE) ? tx_sr[39] : 1'b0;
        end
    end

`ifdef JSTK_LED_CMD_EN
    logic [7:0] pend_r, pend_g, pend_b;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pend_r <= '0;
            pend_g <= '0;
            pend_b <= '0;
            led_r  <= '0;
            led_g  <= '0;
            led_b  <= '0;
        end else begin
            if (sample) begin
                if (bit_cnt == 6'd15) pend_r <= rx_byte;
                if (bit_cnt == 6'd23) pend_g <= rx_byte;
                if (bit_cnt == 6'd31) pend_b <= rx_byte;
            end
            // LEDs only change on a complete frame carrying the set-LED command.
            if (done && cmd == CMD_SET_LED) begin
                led_r <= pend_r;
                led_g <= pend_g;
                led_b <= pend_b;
            end
        end
    end
`else
    assign led_r = 8'h00;
    assign led_g = 8'h00;
    assign led_b = 8'h00;
`endif

endmodule
